instruction_fetch_unit: RTL
===========================

# instruction_fetch_unit

Fetch stage placed directly upstream of the instruction memory. Holds the program counter and drives `Inst_Address`. Captures the returned 32-bit `Instruction` into an IF/ID pipeline register. Handles stall, branch redirect with flush, end-of-program halt and misaligned-target fault, and counts delivered instructions.

## Interface
- `RESET_PC`, 64'd0, PC value loaded on reset.
- `END_ADDR`, 64'd96, first byte address past the program; fetch halts when PC >= END_ADDR.
- `NOP_INST`, 32'h00000013, bubble encoding (addi x0,x0,0) placed in IF/ID on reset and flush.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; sampled on rising edge of `clk`.
- `stall`  in  1  hold PC and IF/ID contents.
- `branch_taken`  in  1  redirect request from downstream branch resolution.
- `branch_target`  in  64  byte address to redirect to.
- `Inst_Address`  out  64  current PC, driven to instruction memory (combinational from PC register).
- `Instruction`  in  32  instruction memory read data, valid in the same cycle as `Inst_Address`.
- `IFID_PC`  out  64  PC of the captured instruction.
- `IFID_Instruction`  out  32  captured instruction.
- `IFID_Valid`  out  1  IF/ID holds a real instruction.
- `Halted`  out  1  high in HALT state.
- `Fault`  out  1  high in FAULT state.
- `fetch_count`  out  32  number of instructions delivered since reset.

## Operation
- States: RUN, HALT, FAULT. Reset enters RUN.
- Reset values: PC=RESET_PC, IFID_PC=0, IFID_Instruction=NOP_INST, IFID_Valid=0, Halted=0, Fault=0, fetch_count=0.
- Per-edge priority: reset > branch_taken > stall > normal fetch.
- RUN, branch_taken, target[1:0]==0:
  - PC<=branch_target.
  - IF/ID flushed: IFID_Valid<=0, IFID_Instruction<=NOP_INST, IFID_PC<=0.
  - fetch_count unchanged.
  - Stall in the same cycle is ignored.
- RUN, branch_taken, target[1:0]!=0:
  - Enter FAULT; IF/ID flushed; PC holds.
- RUN, stall, no branch: PC, IF/ID and fetch_count all hold.
- RUN, normal, PC >= END_ADDR (unsigned compare):
  - Enter HALT; IF/ID flushed; PC holds.
- RUN, normal, PC < END_ADDR:
  - IFID_Instruction<=Instruction, IFID_PC<=PC, IFID_Valid<=1.
  - PC<=PC+4 (64-bit, wraps modulo 2^64).
  - fetch_count<=fetch_count+1 (wraps modulo 2^32).
- HALT:
  - PC and IF/ID hold flushed state; stall has no effect.
  - branch_taken with aligned target: PC<=target, return to RUN. If that target is >= END_ADDR, HALT is re-entered on the next normal cycle.
  - branch_taken with misaligned target: enter FAULT.
- FAULT: sticky until reset. PC holds, IFID_Valid=0, all inputs except reset ignored.
- `Halted` and `Fault` are registered state decodes, never both high.

## Timing
- `Inst_Address` changes only on clock edges. Memory read is combinational, so the instruction at PC is captured at the end of the same cycle.
- Fetch latency: one cycle from PC to IF/ID.
- Throughput: one instruction per cycle when not stalled.
- Branch penalty: one bubble. The edge that samples branch_taken loads the target and flushes IF/ID. The next edge captures the instruction at the target.
- Stall asserted for N cycles delays IF/ID advance by exactly N cycles; no instruction is lost or duplicated.
- Reset asserted mid-operation, with any combination of stall and branch_taken: the next edge applies reset values only.

## Test plan
- Reset, then 3 unstalled cycles with memory returning 0x00100313, 0x00400393, 0x00500413:
  - Inst_Address sequence is 0, 4, 8, 12.
  - IFID_PC sequence is 0, 4, 8 with the matching instructions.
  - IFID_Valid=1 after the first edge.
  - fetch_count=3.
- From PC=8, stall for 2 cycles:
  - Inst_Address stays 8; IFID_PC stays 4; fetch_count is unchanged.
  - On release, PC=8 is captured next.
- Stall and branch_taken with target 0x20 in the same cycle:
  - Next edge: Inst_Address=0x20, IFID_Valid=0, IFID_Instruction=0x00000013.
  - Following edge: IFID_PC=0x20, IFID_Valid=1.
- Free-run to PC=96 with END_ADDR=96:
  - Halted=1, IFID_Valid=0, Inst_Address stays 96.
  - Then branch_taken with target 0x20: Halted=0 and fetch resumes at 0x20.
- branch_taken with target 0x22:
  - Fault=1, IFID_Valid=0.
  - A subsequent aligned branch_taken is ignored.
  - reset clears Fault and returns PC to 0.
- Reset asserted together with branch_taken (target 0x40) and stall at PC=0x30:
  - All outputs take reset values; Inst_Address=0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction memory address and captures
// the returned word into the IF/ID register. Handles stall, branch redirect
// with flush, end-of-program halt and a sticky misaligned-target fault.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter logic [63:0] END_ADDR = 64'd96,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic [63:0] Inst_Address,
  input  logic [31:0] Instruction,
  output logic [63:0] IFID_PC,
  output logic [31:0] IFID_Instruction,
  output logic        IFID_Valid,
  output logic        Halted,
  output logic        Fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StHalt  = 2'd1,
    StFault = 2'd2
  } state_e;

  state_e      state_q;
  logic [63:0] pc_q;
  logic        target_aligned;

  assign target_aligned = (branch_target[1:0] == 2'b00);
  assign Inst_Address   = pc_q;

  // State, PC, IF/ID register, counter and registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= StRun;
      pc_q             <= RESET_PC;
      IFID_PC          <= 64'd0;
      IFID_Instruction <= NOP_INST;
      IFID_Valid       <= 1'b0;
      Halted           <= 1'b0;
      Fault            <= 1'b0;
      fetch_count      <= 32'd0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (branch_taken) begin
            // Redirect wins over stall; the wrong-path word is squashed.
            IFID_PC          <= 64'd0;
            IFID_Instruction <= NOP_INST;
            IFID_Valid       <= 1'b0;
            if (target_aligned) begin
              pc_q <= branch_target;
            end else begin
              state_q <= StFault;
              Fault   <= 1'b1;
            end
          end else if (stall) begin
            // Hold everything.
          end else if (pc_q >= END_ADDR) begin
            state_q          <= StHalt;
            Halted           <= 1'b1;
            IFID_PC          <= 64'd0;
            IFID_Instruction <= NOP_INST;
            IFID_Valid       <= 1'b0;
          end else begin
            IFID_PC          <= pc_q;
            IFID_Instruction <= Instruction;
            IFID_Valid       <= 1'b1;
            pc_q             <= pc_q + 64'd4;
            fetch_count      <= fetch_count + 32'd1;
          end
        end
        StHalt: begin
          // IF/ID is already flushed; only a redirect leaves this state.
          if (branch_taken) begin
            Halted <= 1'b0;
            if (target_aligned) begin
              pc_q    <= branch_target;
              state_q <= StRun;
            end else begin
              state_q <= StFault;
              Fault   <= 1'b1;
            end
          end
        end
        StFault: begin
          // Sticky until reset.
        end
        default: begin
          state_q    <= StFault;
          Halted     <= 1'b0;
          Fault      <= 1'b1;
          IFID_Valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
